// File: rtl/sqrt_mant_iter_if.sv
// Handshake and data bundle for the iterative mantissa square-root core.
// master = operand producer / result consumer, slave = the core itself.
interface sqrt_mant_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic        s_in;
    logic        exp_odd;
    logic [22:0] frac_in;
    logic [2:0]  r_m_in;
    logic        out_valid;
    logic        out_ready;
    logic        s_g;
    logic [2:0]  r_m;
    logic [47:0] m_out;
    logic        busy;

    modport master (
        output in_valid, s_in, exp_odd, frac_in, r_m_in, out_ready,
        input  in_ready, out_valid, s_g, r_m, m_out, busy
    );

    modport slave (
        input  in_valid, s_in, exp_odd, frac_in, r_m_in, out_ready,
        output in_ready, out_valid, s_g, r_m, m_out, busy
    );
endinterface

// File: rtl/sqrt_mant_iter.sv
// Iterative restoring mantissa square root. Resolves BITS_PER_CYCLE root bits
// per clock (1 or 2) and presents a 26-bit root plus sticky to the rounder.
module sqrt_mant_iter #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic            clk,
    input logic            rst_n,
    sqrt_mant_iter_if.slave bus
);

    localparam int unsigned N    = 26 / BITS_PER_CYCLE;
    localparam int unsigned CntW = 5;

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e         r_state;
    logic [51:0]    r_rad;
    logic [27:0]    r_rem;
    logic [25:0]    r_root;
    logic [CntW-1:0] r_cnt;
    logic           r_s_cap;
    logic [2:0]     r_rm_cap;
    logic           r_out_valid;
    logic           r_busy;
    logic           r_s_g;
    logic [2:0]     r_r_m;
    logic [47:0]    r_m_out;

    logic [51:0]    w_x;
    logic [51:0]    w_rad;
    logic [27:0]    w_rem;
    logic [25:0]    w_root;
    logic [29:0]    w_trial;
    logic [29:0]    w_t;

    // Radicand with 2 integer bits; an odd exponent pre-doubles it.
    always_comb begin
        if (bus.exp_odd) begin
            w_x = {1'b1, bus.frac_in, 28'b0};
        end else begin
            w_x = {2'b01, bus.frac_in, 27'b0};
        end
    end

    // One group of restoring digit steps, chained when BITS_PER_CYCLE = 2.
    always_comb begin
        w_rem   = r_rem;
        w_root  = r_root;
        w_rad   = r_rad;
        w_trial = '0;
        w_t     = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            w_trial = {w_rem, w_rad[51:50]};
            w_t     = {2'b00, w_root, 2'b01};
            if (w_trial >= w_t) begin
                w_rem  = 28'(w_trial - w_t);
                w_root = {w_root[24:0], 1'b1};
            end else begin
                // trial < t < 2^28, so the truncation is lossless
                w_rem  = w_trial[27:0];
                w_root = {w_root[24:0], 1'b0};
            end
            w_rad = {w_rad[49:0], 2'b00};
        end
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_rad       <= '0;
            r_rem       <= '0;
            r_root      <= '0;
            r_cnt       <= '0;
            r_s_cap     <= 1'b0;
            r_rm_cap    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_s_g       <= 1'b0;
            r_r_m       <= '0;
            r_m_out     <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_s_cap  <= bus.s_in;
                        r_rm_cap <= bus.r_m_in;
                        r_rad    <= w_x;
                        r_rem    <= '0;
                        r_root   <= '0;
                        r_cnt    <= CntW'(N - 1);
                        r_busy   <= 1'b1;
                        r_state  <= StIter;
                    end
                end
                StIter: begin
                    r_rad  <= w_rad;
                    r_rem  <= w_rem;
                    r_root <= w_root;
                    if (r_cnt == '0) begin
                        r_m_out     <= {w_root, |w_rem, 21'b0};
                        r_s_g       <= r_s_cap;
                        r_r_m       <= r_rm_cap;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        // Back-to-back: a waiting operand starts on the retire edge.
                        if (bus.in_valid) begin
                            r_s_cap  <= bus.s_in;
                            r_rm_cap <= bus.r_m_in;
                            r_rad    <= w_x;
                            r_rem    <= '0;
                            r_root   <= '0;
                            r_cnt    <= CntW'(N - 1);
                            r_busy   <= 1'b1;
                            r_state  <= StIter;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Ready follows the consumer while a result is parked, so issue can overlap retire.
    always_comb begin
        bus.in_ready = (r_state == StIdle) || ((r_state == StDone) && bus.out_ready);
    end

    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.s_g       = r_s_g;
    assign bus.r_m       = r_r_m;
    assign bus.m_out     = r_m_out;

endmodule

// File: tb/tb_sqrt_mant_iter.sv
// Self-checking bench for sqrt_mant_iter: one instance per BITS_PER_CYCLE value,
// directed corner cases plus randomized operands against an integer-sqrt model.
module tb_sqrt_mant_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sqrt_mant_iter_if bus1 ();
    sqrt_mant_iter_if bus2 ();

    sqrt_mant_iter #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    sqrt_mant_iter #(.BITS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    // Largest r with r*r <= X*2^50, found by bisection; sticky if not exact.
    function automatic logic [47:0] model(input bit odd, input logic [22:0] f);
        longint unsigned x, lo, hi, mid;
        logic [25:0] r;
        x  = (64'(f) + 64'd8388608) << (odd ? 28 : 27);
        lo = 0;
        hi = 64'd1 << 26;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid;
        end
        r = lo[25:0];
        return {r, (lo * lo != x), 21'd0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input bit v, input bit s, input bit odd,
                          input logic [22:0] f, input logic [2:0] rm);
        if (sel == 1) begin
            bus1.in_valid = v; bus1.s_in = s; bus1.exp_odd = odd;
            bus1.frac_in = f; bus1.r_m_in = rm;
        end else begin
            bus2.in_valid = v; bus2.s_in = s; bus2.exp_odd = odd;
            bus2.frac_in = f; bus2.r_m_in = rm;
        end
    endtask

    task automatic snap(input int sel, output logic ov, output logic ir, output logic bz,
                        output logic sg, output logic [2:0] rm, output logic [47:0] m);
        if (sel == 1) begin
            ov = bus1.out_valid; ir = bus1.in_ready; bz = bus1.busy;
            sg = bus1.s_g; rm = bus1.r_m; m = bus1.m_out;
        end else begin
            ov = bus2.out_valid; ir = bus2.in_ready; bz = bus2.busy;
            sg = bus2.s_g; rm = bus2.r_m; m = bus2.m_out;
        end
    endtask

    // Issue one operand, wait for its result, check latency, root, sign and mode.
    task automatic run_op(input int sel, input bit s, input bit odd, input logic [22:0] f,
                          input logic [2:0] rm, input bit use_k, input logic [47:0] k_exp);
        logic ov, ir, bz, sg;
        logic [2:0] orm;
        logic [47:0] m;
        int n, cyc;
        bit ok;
        n = (sel == 1) ? 26 : 13;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            snap(sel, ov, ir, bz, sg, orm, m);
            if (ir) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            check("accept_timeout", 64'(ok), 64'd1);
            return;
        end
        set_in(sel, 1'b1, s, odd, f, rm);
        @(posedge clk); #1;
        set_in(sel, 1'b0, 1'b0, 1'b0, 23'd0, 3'd0);
        snap(sel, ov, ir, bz, sg, orm, m);
        check("busy_after_accept", 64'(bz), 64'd1);
        cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cyc++;
            snap(sel, ov, ir, bz, sg, orm, m);
            if (ov) begin ok = 1'b1; break; end
        end
        check("result_timeout", 64'(ok), 64'd1);
        check("latency", 64'(cyc), 64'(n));
        check("m_out", 64'(m), 64'(model(odd, f)));
        check("s_g", 64'(sg), 64'(s));
        check("r_m", 64'(orm), 64'(rm));
        if (use_k) check("m_out_const", 64'(m), 64'(k_exp));
    endtask

    initial begin
        logic ov, ir, bz, sg;
        logic [2:0] orm, hrm;
        logic [47:0] m, hm;
        logic hsg;
        bit seen;

        bus1.out_ready = 1'b1;
        bus2.out_ready = 1'b1;
        set_in(1, 1'b0, 1'b0, 1'b0, 23'd0, 3'd0);
        set_in(2, 1'b0, 1'b0, 1'b0, 23'd0, 3'd0);

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        for (int sel = 1; sel <= 2; sel++) begin
            snap(sel, ov, ir, bz, sg, orm, m);
            check("rst_out_valid", 64'(ov), 64'd0);
            check("rst_busy", 64'(bz), 64'd0);
            check("rst_m_out", 64'(m), 64'd0);
            check("rst_s_g", 64'(sg), 64'd0);
            check("rst_r_m", 64'(orm), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        snap(1, ov, ir, bz, sg, orm, m);
        check("rst_in_ready", 64'(ir), 64'd1);

        // Known roots on both step widths.
        for (int sel = 1; sel <= 2; sel++) begin
            run_op(sel, 1'b0, 1'b0, 23'd0, 3'd1, 1'b1, 48'h8000_0000_0000);
            run_op(sel, 1'b1, 1'b1, 23'd0, 3'd2, 1'b1, 48'hB504_F320_0000);
            run_op(sel, 1'b0, 1'b1, 23'h100000, 3'd4, 1'b1, 48'hC000_0000_0000);
        end

        // Consumer stall: result parked and stable, ready low, then back-to-back issue.
        bus1.out_ready = 1'b0;
        run_op(1, 1'b1, 1'b0, 23'h2AAAAA, 3'd3, 1'b0, 48'd0);
        snap(1, ov, ir, bz, hsg, hrm, hm);
        for (int i = 0; i < 10; i++) begin
            set_in(1, 1'b1, 1'b0, 1'b1, 23'h7FFFFF, 3'd6);
            @(posedge clk); #1;
            snap(1, ov, ir, bz, sg, orm, m);
            check("stall_out_valid", 64'(ov), 64'd1);
            check("stall_in_ready", 64'(ir), 64'd0);
            check("stall_m_out", 64'(m), 64'(hm));
            check("stall_s_g", 64'(sg), 64'(hsg));
            check("stall_r_m", 64'(orm), 64'(hrm));
        end
        set_in(1, 1'b0, 1'b0, 1'b0, 23'd0, 3'd0);
        bus1.out_ready = 1'b1;
        run_op(1, 1'b0, 1'b1, 23'h7FFFFF, 3'd6, 1'b0, 48'd0);

        // Reset mid-iteration discards the operation.
        set_in(1, 1'b1, 1'b1, 1'b0, 23'h123456, 3'd5);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 1'b0, 23'd0, 3'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        snap(1, ov, ir, bz, sg, orm, m);
        check("midrst_out_valid", 64'(ov), 64'd0);
        check("midrst_m_out", 64'(m), 64'd0);
        check("midrst_busy", 64'(bz), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        snap(1, ov, ir, bz, sg, orm, m);
        check("midrst_in_ready", 64'(ir), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            snap(1, ov, ir, bz, sg, orm, m);
            if (ov || bz) seen = 1'b1;
        end
        check("midrst_no_result", 64'(seen), 64'd0);

        // Randomized operands on both step widths.
        for (int sel = 1; sel <= 2; sel++) begin
            for (int i = 0; i < 1000; i++) begin
                run_op(sel, 1'($urandom), 1'($urandom), 23'($urandom),
                       3'($urandom_range(0, 7)), 1'b0, 48'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
